// File: rtl/hazard_control_unit.sv
// Pipeline sequencer beside ID: load-use stalls, memory-busy freeze, branch squash, and registered EX forwarding selects.
// Control outputs are combinational in the hazard cycle; forwarding selects take effect one cycle later and hold while the pipe is frozen.
module hazard_control_unit #(
  parameter int REG_NUM_W         = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_NUM_W-1:0] id_src1_num,
  input  logic                 id_src1_used,
  input  logic [REG_NUM_W-1:0] id_src2_num,
  input  logic                 id_src2_used,
  input  logic [REG_NUM_W-1:0] ex_dst_num,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic [REG_NUM_W-1:0] mem_dst_num,
  input  logic                 mem_reg_write,
  input  logic                 mem_busy,
  input  logic                 branch_taken,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_hold,
  output logic [1:0]           fwd_sel_1,
  output logic [1:0]           fwd_sel_2,
  output logic [1:0]           ctrl_state,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_LSTALL = 2'b01;
  localparam logic [1:0] ST_MWAIT  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] BCNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [1:0]       fwd1_q, fwd2_q;
  logic [1:0]       fwd1_calc, fwd2_calc;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [1:0]       eff_state;
  logic             src1_hit_ex, src2_hit_ex;
  logic             src1_hit_mem, src2_hit_mem;
  logic             load_use;

  assign src1_hit_ex  = id_src1_used & ex_reg_write  & (id_src1_num == ex_dst_num);
  assign src2_hit_ex  = id_src2_used & ex_reg_write  & (id_src2_num == ex_dst_num);
  assign src1_hit_mem = id_src1_used & mem_reg_write & (id_src1_num == mem_dst_num);
  assign src2_hit_mem = id_src2_used & mem_reg_write & (id_src2_num == mem_dst_num);

  assign load_use = ex_mem_read & (src1_hit_ex | src2_hit_ex);

  // Leaving MWAIT behaves exactly like the state that was frozen.
  assign eff_state = (state_q == ST_MWAIT) ? saved_q : state_q;

  always_comb begin
    fwd1_calc = src1_hit_ex ? FWD_ALU : (src1_hit_mem ? FWD_MEM : FWD_RF);
    fwd2_calc = src2_hit_ex ? FWD_ALU : (src2_hit_mem ? FWD_MEM : FWD_RF);
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    state_d     = ST_RUN;
    saved_d     = saved_q;
    bcnt_d      = bcnt_q;

    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      saved_d    = ST_RUN;
      bcnt_d     = 4'd0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_d    = ST_MWAIT;
      saved_d    = eff_state;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
      bcnt_d      = 4'd0;
    end else if (eff_state == ST_LSTALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      bcnt_d      = bcnt_q - 4'd1;
      state_d     = (bcnt_q <= 4'd1) ? ST_RUN : ST_LSTALL;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        bcnt_d  = BCNT_INIT;
        state_d = ST_LSTALL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      bcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Selects freeze with the rest of the pipe; a squashed/bubbled slot forwards nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd1_q <= FWD_RF;
      fwd2_q <= FWD_RF;
    end else if (!pipe_hold) begin
      if (idex_bubble || ifid_flush) begin
        fwd1_q <= FWD_RF;
        fwd2_q <= FWD_RF;
      end else begin
        fwd1_q <= fwd1_calc;
        fwd2_q <= fwd2_calc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_sel_1  = fwd1_q;
  assign fwd_sel_2  = fwd2_q;
  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: default instance plus a LOAD_STALL_CYCLES=3 instance on shared inputs.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1_num, id_src2_num, ex_dst_num, mem_dst_num;
  logic       id_src1_used, id_src2_used, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, mem_busy, branch_taken;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0]  fwd_sel_1, fwd_sel_2, ctrl_state;
  logic [15:0] stall_cnt;

  logic        d3_pc_write, d3_ifid_write, d3_ifid_flush, d3_idex_bubble, d3_pipe_hold;
  logic [1:0]  d3_fwd_sel_1, d3_fwd_sel_2, d3_ctrl_state;
  logic [15:0] d3_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_dut (
    .clk(clk), .rst(rst),
    .id_src1_num(id_src1_num), .id_src1_used(id_src1_used),
    .id_src2_num(id_src2_num), .id_src2_used(id_src2_used),
    .ex_dst_num(ex_dst_num), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst_num(mem_dst_num), .mem_reg_write(mem_reg_write),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .id_src1_num(id_src1_num), .id_src1_used(id_src1_used),
    .id_src2_num(id_src2_num), .id_src2_used(id_src2_used),
    .ex_dst_num(ex_dst_num), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst_num(mem_dst_num), .mem_reg_write(mem_reg_write),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_write(d3_pc_write), .ifid_write(d3_ifid_write), .ifid_flush(d3_ifid_flush),
    .idex_bubble(d3_idex_bubble), .pipe_hold(d3_pipe_hold),
    .fwd_sel_1(d3_fwd_sel_1), .fwd_sel_2(d3_fwd_sel_2),
    .ctrl_state(d3_ctrl_state), .stall_cnt(d3_stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1_num = 4'd0; id_src1_used = 1'b0;
    id_src2_num = 4'd0; id_src2_used = 1'b0;
    ex_dst_num = 4'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_dst_num = 4'd0; mem_reg_write = 1'b0;
    mem_busy = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic set_load_use_r3();
    clear_inputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst_num = 4'd3;
    id_src1_num = 4'd3; id_src1_used = 1'b1;
  endtask

  task automatic set_mem_fwd_r3();
    clear_inputs();
    mem_reg_write = 1'b1; mem_dst_num = 4'd3;
    id_src1_num = 4'd3; id_src1_used = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    chk("rst_state", 16'(ctrl_state), 16'h0);
    chk("rst_fwd1", 16'(fwd_sel_1), 16'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    chk("rst_pipe_hold", 16'(pipe_hold), 16'h1);
    chk("rst_pc_write", 16'(pc_write), 16'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("run_pc_write", 16'(pc_write), 16'h1);
    chk("run_pipe_hold", 16'(pipe_hold), 16'h0);
    tick();
    chk("run_stall_cnt", stall_cnt, 16'h0);

    // Load-use, single bubble, then load forwarded from MEM.
    set_load_use_r3();
    #1;
    chk("lu_pc_write", 16'(pc_write), 16'h0);
    chk("lu_ifid_write", 16'(ifid_write), 16'h0);
    chk("lu_bubble", 16'(idex_bubble), 16'h1);
    tick();
    chk("lu_next_state", 16'(ctrl_state), 16'h0);
    chk("lu_fwd1_bubbled", 16'(fwd_sel_1), 16'h0);
    chk("lu_stall_cnt", stall_cnt, 16'h1);
    set_mem_fwd_r3();
    #1;
    chk("lu2_pc_write", 16'(pc_write), 16'h1);
    tick();
    chk("lu2_fwd1_mem", 16'(fwd_sel_1), 16'h2);

    // EX beats MEM on operand 2; operand 1 unmatched.
    clear_inputs();
    ex_reg_write = 1'b1; ex_dst_num = 4'd5;
    mem_reg_write = 1'b1; mem_dst_num = 4'd5;
    id_src2_num = 4'd5; id_src2_used = 1'b1;
    id_src1_num = 4'd2; id_src1_used = 1'b1;
    tick();
    chk("prio_fwd2", 16'(fwd_sel_2), 16'h1);
    chk("prio_fwd1", 16'(fwd_sel_1), 16'h0);

    // Branch wins over load-use.
    set_load_use_r3();
    mem_reg_write = 1'b1; mem_dst_num = 4'd7;
    id_src2_num = 4'd7; id_src2_used = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("br_flush", 16'(ifid_flush), 16'h1);
    chk("br_bubble", 16'(idex_bubble), 16'h1);
    chk("br_pc_write", 16'(pc_write), 16'h1);
    chk("br_ifid_write", 16'(ifid_write), 16'h1);
    tick();
    chk("br_fwd1", 16'(fwd_sel_1), 16'h0);
    chk("br_fwd2", 16'(fwd_sel_2), 16'h0);
    chk("br_stall_cnt", stall_cnt, 16'h1);
    chk("br_state", 16'(ctrl_state), 16'h0);

    // LOAD_STALL_CYCLES=3 with a 2-cycle memory freeze inside LSTALL.
    clear_inputs();
    do_reset();
    set_load_use_r3();
    #1;
    chk("ls3_a_bubble", 16'(d3_idex_bubble), 16'h1);
    tick();
    chk("ls3_a_state", 16'(d3_ctrl_state), 16'h1);
    clear_inputs();
    mem_busy = 1'b1;
    #1;
    chk("ls3_b_hold", 16'(d3_pipe_hold), 16'h1);
    chk("ls3_b_bubble", 16'(d3_idex_bubble), 16'h0);
    chk("ls3_b_pc_write", 16'(d3_pc_write), 16'h0);
    tick();
    chk("ls3_b_state", 16'(d3_ctrl_state), 16'h2);
    tick();
    chk("ls3_c_state", 16'(d3_ctrl_state), 16'h2);
    mem_busy = 1'b0;
    #1;
    chk("ls3_d_bubble", 16'(d3_idex_bubble), 16'h1);
    chk("ls3_d_hold", 16'(d3_pipe_hold), 16'h0);
    tick();
    chk("ls3_d_state", 16'(d3_ctrl_state), 16'h1);
    tick();
    chk("ls3_e_state", 16'(d3_ctrl_state), 16'h0);
    chk("ls3_stall_cnt", d3_stall_cnt, 16'd5);
    chk("ls3_f_pc_write", 16'(d3_pc_write), 16'h1);

    // Asynchronous reset mid-LSTALL.
    do_reset();
    set_load_use_r3();
    tick();
    set_mem_fwd_r3();
    tick();
    chk("ar_pre_state", 16'(d3_ctrl_state), 16'h1);
    chk("ar_pre_fwd1", 16'(fwd_sel_1), 16'h2);
    #2;
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("ar_state", 16'(d3_ctrl_state), 16'h0);
    chk("ar_fwd1", 16'(fwd_sel_1), 16'h0);
    chk("ar_stall_cnt", d3_stall_cnt, 16'h0);
    chk("ar_hold", 16'(d3_pipe_hold), 16'h1);
    rst = 1'b1;
    #1;
    chk("ar_rel_pc_write", 16'(d3_pc_write), 16'h1);
    tick();
    chk("ar_rel_state", 16'(d3_ctrl_state), 16'h0);

    // Stall counter saturation via a long memory freeze.
    do_reset();
    mem_busy = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    mem_busy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the five-stage core, sitting beside the ID stage.
- Detects load-use hazards, memory-busy freezes and taken-branch squashes, and drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.
- Produces the registered per-operand forwarding selects that steer the EX-stage operand muxes between register file, EX/MEM ALU result and MEM/WB memory data.

Parameters:
- REG_NUM_W, 4, register-number width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- id_src1_num  input  REG_NUM_W  ID-stage source 1 register number.
- id_src1_used  input  1  source 1 is read by the ID instruction.
- id_src2_num  input  REG_NUM_W  ID-stage source 2 register number.
- id_src2_used  input  1  source 2 is read.
- ex_dst_num  input  REG_NUM_W  destination of the instruction in EX.
- ex_reg_write  input  1  EX instruction writes a register.
- ex_mem_read  input  1  EX instruction is a load.
- mem_dst_num  input  REG_NUM_W  destination of the instruction in MEM.
- mem_reg_write  input  1  MEM instruction writes a register.
- mem_busy  input  1  data memory not ready; whole pipe must freeze.
- branch_taken  input  1  taken branch/jump resolved this cycle.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  clear IF/ID to NOP.
- idex_bubble  output  1  load NOP into ID/EX.
- pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- fwd_sel_1  output  2  EX operand 1 select: 00 regfile, 01 ALU (EX/MEM), 10 memory (MEM/WB).
- fwd_sel_2  output  2  EX operand 2 select, same encoding.
- ctrl_state  output  2  00 RUN, 01 LSTALL, 10 MWAIT.
- stall_cnt  output  CNT_W  cycles with pc_write=0 since reset.

Behaviour:
- Reset (rst=0, immediate): state RUN, fwd_sel_1/2=00, stall_cnt=0, internal bubble counter=0.
- While rst=0, combinational outputs are: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
- Reset deasserted mid-stall: the machine restarts in RUN; no pending stall survives.
- load_use (combinational) = ex_mem_read & ex_reg_write & ((id_src1_used & id_src1_num==ex_dst_num) | (id_src2_used & id_src2_num==ex_dst_num)).
- Priority in every state: mem_busy > branch_taken > load_use/LSTALL.
- MWAIT entry: mem_busy=1 forces pipe_hold=1, pc_write=0 and ifid_write=0 in the same cycle. ifid_flush=0, idex_bubble=0, and fwd_sel registers hold. Next state is MWAIT.
- MWAIT exit: on mem_busy=0, return to the state saved on entry (RUN or LSTALL), with the bubble counter preserved. In that cycle outputs are evaluated as in the saved state.
- branch_taken (no mem_busy): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Any load-use or remaining LSTALL count is cancelled, next state RUN, no stall counted.
- RUN, load_use (no branch, no busy): pc_write=0, ifid_write=0, idex_bubble=1 this cycle.
  - LOAD_STALL_CYCLES=1: next state RUN.
  - Otherwise: load counter with LOAD_STALL_CYCLES-1, go LSTALL.
- LSTALL: same stall outputs as a RUN load_use cycle. Decrement the counter each cycle; at count 1, next state is RUN.
- RUN, no hazard: pc_write=1, ifid_write=1, all other controls 0.
- Forwarding selects are updated on the rising clk edge when pipe_hold=0, and used by EX in the following cycle:
  - per operand: if srcN_used & ex_reg_write & srcN==ex_dst_num, select 01;
  - else if srcN_used & mem_reg_write & srcN==mem_dst_num, select 10;
  - else 00.
  - EX has priority over MEM when both match.
  - If idex_bubble=1 or ifid_flush=1 in that cycle, both selects register 00.
- A load stalled one cycle re-evaluates with the load in MEM, yielding 10.
- stall_cnt increments on each rising edge where rst=1 and pc_write=0, including MWAIT. It saturates at all-ones, with no wrap.

Test Plan:
- ex_mem_read=1, ex_reg_write=1, ex_dst=3, id_src1=3 used -> same cycle pc_write=0, idex_bubble=1, next state RUN. Next cycle (mem_dst=3, mem_reg_write=1, no EX match) -> fwd_sel_1=10 after the edge.
- ex_reg_write=1, ex_dst=5, mem_reg_write=1, mem_dst=5, id_src2=5 used, id_src1=2 -> after the edge fwd_sel_2=01, fwd_sel_1=00.
- load_use and branch_taken in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, fwd_sels register 00, stall_cnt unchanged.
- LOAD_STALL_CYCLES=3, load_use, then mem_busy high for 2 cycles during LSTALL -> 3 bubble cycles plus 2 hold cycles, then RUN; stall_cnt=5.
- Pulse rst low while in LSTALL with fwd_sel_1=10 -> immediately ctrl_state=00, fwd_sel_1=00, stall_cnt=0, pipe_hold=1. After release, RUN with pc_write=1.
- Force 65535 stall cycles (CNT_W=16) then one more -> stall_cnt stays 16'hFFFF.
